// File: rtl/change_hopper_ctrl.sv
// Coin-hopper payout controller: queues owed 5-unit coins, drives the hopper
// motor one coin at a time, confirms on coin_sense, retries, and latches faults.
module change_hopper_ctrl #(
    parameter int unsigned PEND_W  = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned RETRIES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              change_req,
    input  logic              coin_sense,
    output logic              motor_on,
    output logic              coin_paid,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              overflow,
    output logic              fault
);

    localparam int unsigned TMR_MAX  = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
    localparam int unsigned RTRY_W   = $clog2(RETRIES + 2);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TMR_W-1:0]    timer;
    logic [RTRY_W-1:0]   retry_cnt;
    logic                sense_q;
    logic [PEND_W-1:0]   pend_nxt;

    logic sense_edge_c;
    logic pay_c;
    logic timeout_c;
    logic settle_done_c;
    logic drop_c;

    // Event decode and next-state / next-pending computation from registered state.
    always_comb begin
        sense_edge_c  = coin_sense & ~sense_q;
        pay_c         = (state == ST_DRIVE) && sense_edge_c;
        timeout_c     = (state == ST_DRIVE) && !sense_edge_c &&
                        (timer == TMR_W'(TIMEOUT - 1));
        settle_done_c = (state == ST_SETTLE) && (timer == TMR_W'(SETTLE - 1));
        drop_c        = change_req && !pay_c && (pending == PEND_MAX);

        pend_nxt = pending;
        if (change_req && !pay_c && (pending != PEND_MAX)) begin
            pend_nxt = pending + PEND_W'(1);
        end else if (pay_c && !change_req) begin
            pend_nxt = pending - PEND_W'(1);
        end

        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pending != '0) begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (pay_c) begin
                    state_nxt = ST_SETTLE;
                end else if (timeout_c) begin
                    state_nxt = (retry_cnt < RTRY_W'(RETRIES)) ? ST_SETTLE : ST_FAULT;
                end
            end
            ST_SETTLE: begin
                if (settle_done_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_FAULT;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            sense_q   <= 1'b0;
            pending   <= '0;
            motor_on  <= 1'b0;
            coin_paid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state   <= state_nxt;
            sense_q <= coin_sense;
            pending <= pend_nxt;

            // Timer restarts on every state change and counts within DRIVE/SETTLE.
            if (state_nxt != state) begin
                timer <= '0;
            end else if ((state == ST_DRIVE) || (state == ST_SETTLE)) begin
                timer <= timer + TMR_W'(1);
            end

            // Retry budget is only consumed by consecutive timeouts.
            if (pay_c) begin
                retry_cnt <= '0;
            end else if (timeout_c && (retry_cnt < RTRY_W'(RETRIES))) begin
                retry_cnt <= retry_cnt + RTRY_W'(1);
            end

            motor_on  <= (state_nxt == ST_DRIVE);
            coin_paid <= pay_c;
            busy      <= (state_nxt != ST_IDLE) || (pend_nxt != '0);
            overflow  <= overflow | drop_c;
            fault     <= fault | (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_change_hopper_ctrl.sv
// Directed bench for change_hopper_ctrl: vector table for normal payout,
// plus hand sequences for the timeout/fault and overflow corner cases.
module tb_change_hopper_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       change_req;
    logic       coin_sense;
    logic       motor_on;
    logic       coin_paid;
    logic [3:0] pending;
    logic       busy;
    logic       overflow;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    change_hopper_ctrl #(
        .PEND_W (4),
        .TIMEOUT(16),
        .SETTLE (2),
        .RETRIES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .change_req(change_req),
        .coin_sense(coin_sense),
        .motor_on  (motor_on),
        .coin_paid (coin_paid),
        .pending   (pending),
        .busy      (busy),
        .overflow  (overflow),
        .fault     (fault)
    );

    typedef struct {
        logic       rst;
        logic       req;
        logic       cs;
        logic       motor;
        logic       paid;
        logic [3:0] pend;
        logic       busy;
        logic       ovf;
        logic       flt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic req, logic cs, logic motor, logic paid,
                                logic [3:0] pend, logic bsy, logic ovf, logic flt);
        vec_t v;
        v.rst = rst; v.req = req; v.cs = cs;
        v.motor = motor; v.paid = paid; v.pend = pend;
        v.busy = bsy; v.ovf = ovf; v.flt = flt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " motor_on"},  32'(motor_on),  32'(v.motor));
        check({tag, " coin_paid"}, 32'(coin_paid), 32'(v.paid));
        check({tag, " pending"},   32'(pending),   32'(v.pend));
        check({tag, " busy"},      32'(busy),      32'(v.busy));
        check({tag, " overflow"},  32'(overflow),  32'(v.ovf));
        check({tag, " fault"},     32'(fault),     32'(v.flt));
    endtask

    initial begin
        reset      = 1'b1;
        change_req = 1'b0;
        coin_sense = 1'b0;

        // rst req cs | motor paid pend busy ovf flt  (outputs after the edge)
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)); // reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0)); // single request
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 0)); // sensed after 3 motor cycles
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0)); // three back-to-back requests
        vecs.push_back(mk(0, 1, 0, 1, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0)); // request coinciding with a sense edge
        vecs.push_back(mk(0, 1, 0, 1, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)); // reset mid-DRIVE
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)); // sense edge in IDLE
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)); // sense edge in SETTLE
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            reset      = vecs[i].rst;
            change_req = vecs[i].req;
            coin_sense = vecs[i].cs;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Coin never sensed: three timed-out attempts, then FAULT.
        reset = 1'b1; change_req = 1'b0; coin_sense = 1'b0;
        tick();
        reset = 1'b0; change_req = 1'b1;
        tick();
        check("to_req pending", 32'(pending), 32'd1);
        check("to_req motor_on", 32'(motor_on), 32'd0);
        change_req = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            logic exp_motor;
            logic exp_fault;
            tick();
            exp_motor = (c <= 54) && (((c - 1) % 19) < 16);
            exp_fault = (c >= 55);
            check($sformatf("to_c%0d motor_on", c), 32'(motor_on), 32'(exp_motor));
            check($sformatf("to_c%0d fault", c), 32'(fault), 32'(exp_fault));
            check($sformatf("to_c%0d pending", c), 32'(pending), 32'd1);
        end

        // Sensor activity in FAULT is ignored.
        for (int c = 0; c < 6; c++) begin
            coin_sense = ~coin_sense;
            tick();
            check($sformatf("flt_cs%0d coin_paid", c), 32'(coin_paid), 32'd0);
            check($sformatf("flt_cs%0d motor_on", c), 32'(motor_on), 32'd0);
        end
        coin_sense = 1'b0;

        // Requests in FAULT saturate pending at 15 and set overflow.
        for (int k = 1; k <= 16; k++) begin
            change_req = 1'b1;
            tick();
            check($sformatf("ovf_k%0d pending", k), 32'(pending), 32'((k + 1 > 15) ? 15 : k + 1));
            check($sformatf("ovf_k%0d overflow", k), 32'(overflow), 32'(k >= 15));
        end
        change_req = 1'b0;
        tick();
        check("ovf_end fault", 32'(fault), 32'd1);
        check("ovf_end busy", 32'(busy), 32'd1);
        check("ovf_end overflow", 32'(overflow), 32'd1);

        // Reset clears the sticky flags.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all("final_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/change_hopper_ctrl.md
# change_hopper_ctrl

Change-payout controller for the vending machine. It sits on the output side of the vending machine core, at the far end of its change signal. Each change request pulse counts as one 5-unit coin owed. The block queues those coins and drives the coin-hopper motor one coin at a time. It confirms each payout on the hopper's coin-sense input, retries when a coin is not sensed in time, and latches a fault when the hopper is jammed or empty.

## Interface
Parameters:
- PEND_W, 4: width of the pending-coin counter; maximum pending is 2^PEND_W-1.
- TIMEOUT, 16: cycles the motor runs per attempt before that attempt is declared failed (≥2).
- SETTLE, 2: motor-off cycles after each attempt, whether it succeeded or timed out (≥1).
- RETRIES, 2: extra attempts allowed after a timeout; FAULT is entered after RETRIES+1 consecutive timeouts.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high; clears all state.
- change_req, input, 1: one-cycle pulse per 5-unit coin owed; driven from the core's five_out.
- coin_sense, input, 1: hopper exit sensor, level; one coin = one rising edge.
- motor_on, output, 1: hopper motor drive.
- coin_paid, output, 1: one-cycle pulse per confirmed coin.
- pending, output, PEND_W: coins still owed.
- busy, output, 1: high when state≠IDLE or pending≠0.
- overflow, output, 1: sticky; a request was dropped because pending was saturated.
- fault, output, 1: sticky; hopper failure.

## Operation
- Reset values: motor_on=0, coin_paid=0, pending=0, busy=0, overflow=0, fault=0. State=IDLE; timer, retry count and coin_sense history register all 0.
- Edge detect: sense_edge = coin_sense & ~sense_q, where sense_q is coin_sense registered.
  - sense_edge is acted on only in DRIVE.
  - Edges in any other state are ignored.
- Pending counter:
  - +1 on change_req.
  - −1 on a confirmed coin.
  - Both in the same cycle: pending is unchanged.
  - change_req while pending is at maximum with no decrement that cycle: the request is dropped and overflow is set.
  - pending never wraps.
- States:
  - IDLE: motor off. If pending≠0 at the clock edge, go to DRIVE with timer cleared.
  - DRIVE: motor_on=1; timer increments each cycle.
    - sense_edge: coin_paid pulses, pending decrements, retry count clears, go to SETTLE.
    - Otherwise, if timer==TIMEOUT-1: timeout. If retry count<RETRIES, increment retry count and go to SETTLE; else go to FAULT.
    - sense_edge wins if it coincides with the timeout cycle.
  - SETTLE: motor off for SETTLE cycles, then go to IDLE. IDLE re-enters DRIVE next cycle if pending≠0.
  - FAULT: motor off; fault=1; absorbing until reset.
    - change_req still increments pending, and overflow rules still apply.
    - coin_sense is ignored.
- Retry count persists across coins only through timeouts; any success clears it.
- Reset asserted in any state, mid-DRIVE included: everything returns to reset values on that edge, pending is discarded, and the motor stops immediately in the next cycle.

## Timing
- All outputs are registered or decoded from registered state. No combinational input-to-output path.
- change_req sampled at edge N: pending is updated after N and DRIVE is entered at edge N+1 (from IDLE). motor_on is therefore high starting 1 cycle after pending becomes nonzero.
- coin_sense rising edge sampled at edge M in DRIVE: after edge M, coin_paid=1 for one cycle, pending is decremented and motor_on=0.
- A failed attempt holds motor_on high for exactly TIMEOUT cycles.
- Minimum per-coin turnaround: 1 (DRIVE) + SETTLE + 1 (IDLE) cycles.

## Test plan
- Reset then one change_req, coin_sense rising 3 cycles after motor_on rises. Required:
  - pending=1, then motor_on 1 cycle later for 3 cycles.
  - coin_paid single pulse; pending=0.
  - motor off for 2 cycles, then back to IDLE; busy low afterward.
- Three back-to-back change_req pulses, sensor answering each attempt after 2 cycles. Required:
  - pending 3→2→1→0, with three coin_paid pulses.
  - motor bursts of 2 cycles separated by 3 off cycles (2 settle + 1 idle).
- One request with coin_sense held low. Required:
  - motor_on pattern 16 on / 2 off / 1 idle / 16 on / 2 off / 1 idle / 16 on.
  - Then fault=1, motor_on stays 0, pending stays 1.
- Sixteen change_req pulses while in FAULT with PEND_W=4, starting from pending=1. Required: pending saturates at 15 and overflow=1.
- change_req in the same cycle as a sense edge, with pending=2. Required: pending stays 2 and coin_paid pulses.
- reset asserted mid-DRIVE with pending=3, and coin_sense edges while in IDLE/SETTLE. Required:
  - After reset, all outputs are 0 on the next cycle.
  - Sense edges outside DRIVE never pulse coin_paid.
